pio_input_capture: RTL and testbench

Parametrised input PIO that replaces the fixed-width pushbutton and switches inputs with a single generic Avalon-MM slave. It has these functions:
- Synchronises and per-bit debounces WIDTH asynchronous board inputs.
- Records rising and/or falling edges in a sticky, write-1-to-clear capture register.
- Drives a maskable level interrupt to the Nios II.

It sits between the board pins and the system interconnect, one instance per input group (keys, switches).

---
 rtl/pio_input_capture.sv | 151 +++++++++++++++
 tb/tb_pio_input_capture.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pio_input_capture.sv
// Input PIO: synchronise, debounce (PIO_INPUT_CAPTURE_DEBOUNCE_EN), sticky W1C edge capture, masked level irq.
// Input-to-DATA latency SYNC_STAGES+DEBOUNCE_CYCLES edges (SYNC_STAGES+1 without debounce); read latency 1, no waitrequest.
module pio_input_capture #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] in_export,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("pio_input_capture: illegal parameter combination");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in_export;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d;

`ifdef PIO_INPUT_CAPTURE_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q [WIDTH];
    logic [CW-1:0] cnt_d [WIDTH];

    // A bit flips only after s has disagreed with deb for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    assign deb_d = s;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb_d;
        end
    end

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] edge_set, edge_clr;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             unused_wdata;

    assign unused_wdata = ^avs_writedata;

    // Edges are taken from deb_d so capture lands on the same edge as the DATA update.
    always_comb begin
        edge_set = ({WIDTH{ctrl_q[0]}} &  deb_d & ~deb_q)
                 | ({WIDTH{ctrl_q[1]}} & ~deb_d &  deb_q);
        edge_clr = '0;
        mask_d   = mask_q;
        ctrl_d   = ctrl_q;
        if (avs_write) begin
            case (avs_address)
                ADDR_MASK: mask_d   = avs_writedata[WIDTH-1:0];
                ADDR_EDGE: edge_clr = avs_writedata[WIDTH-1:0];
                ADDR_CTRL: ctrl_d   = avs_writedata[1:0];
                default:   ;
            endcase
        end
        edge_d = (edge_q & ~edge_clr) | edge_set;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            case (avs_address)
                ADDR_DATA: rdata_d = 32'(deb_q);
                ADDR_MASK: rdata_d = 32'(mask_q);
                ADDR_EDGE: rdata_d = 32'(edge_q);
                ADDR_CTRL: rdata_d = {30'b0, ctrl_q};
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            mask_q  <= '0;
            edge_q  <= '0;
            ctrl_q  <= 2'b01;
            rdata_q <= '0;
        end else begin
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_input_capture.sv
module tb_pio_input_capture;
    localparam int W  = 8;
    localparam int SS = 2;
    localparam int DC = 4;
`ifdef PIO_INPUT_CAPTURE_DEBOUNCE_EN
    localparam int DC_EFF = DC;
`else
    localparam int DC_EFF = 1;
`endif
    localparam int L = SS + DC_EFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_export = '0;
    logic [1:0]    avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [31:0]   avs_readdata;
    logic          irq;

    pio_input_capture #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
        .clk_clk(clk), .reset_reset(rst), .in_export(in_export),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: DATA follows the synchronised input once the last DC_EFF samples all disagree with it.
    logic [W-1:0] m_sync [SS];
    logic [W-1:0] m_hist [$];
    logic [W-1:0] m_deb, m_mask, m_edge, m_s_old, m_deb_new, m_set, m_clr;
    logic [1:0]   m_ctrl;
    logic [31:0]  m_rdata;
    bit           m_all;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SS; k++) m_sync[k] = '0;
            m_hist.delete();
            m_deb = '0; m_mask = '0; m_edge = '0; m_ctrl = 2'b01; m_rdata = '0;
        end else begin
            m_s_old = m_sync[SS-1];
            for (int k = SS-1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = in_export;
            m_hist.push_back(m_s_old);
            if (m_hist.size() > DC_EFF) void'(m_hist.pop_front());
            m_deb_new = m_deb;
            for (int i = 0; i < W; i++) begin
                m_all = (m_hist.size() == DC_EFF);
                foreach (m_hist[j]) if (m_hist[j][i] == m_deb[i]) m_all = 1'b0;
                if (m_all) m_deb_new[i] = ~m_deb[i];
            end
            m_set = '0;
            for (int i = 0; i < W; i++) begin
                if (m_ctrl[0] && !m_deb[i] && m_deb_new[i]) m_set[i] = 1'b1;
                if (m_ctrl[1] && m_deb[i] && !m_deb_new[i]) m_set[i] = 1'b1;
            end
            if (avs_read) begin
                case (avs_address)
                    2'd0: m_rdata = {24'b0, m_deb};
                    2'd1: m_rdata = {24'b0, m_mask};
                    2'd2: m_rdata = {24'b0, m_edge};
                    default: m_rdata = {30'b0, m_ctrl};
                endcase
            end
            m_clr = '0;
            if (avs_write) begin
                case (avs_address)
                    2'd1: m_mask = avs_writedata[W-1:0];
                    2'd2: m_clr  = avs_writedata[W-1:0];
                    2'd3: m_ctrl = avs_writedata[1:0];
                    default: ;
                endcase
            end
            m_edge = (m_edge & ~m_clr) | m_set;
            m_deb  = m_deb_new;
        end
    end

    function automatic logic m_irq();
        return |(m_edge & m_mask);
    endfunction

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("irq_vs_model", 32'(irq), 32'(m_irq()));
            check("readdata_vs_model", avs_readdata, m_rdata);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        cyc(1);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        avs_address = a; avs_writedata = v; avs_write = 1'b1;
        cyc(1);
        avs_write = 1'b0;
    endtask

    logic [31:0] d;
    int          b;
    int          op;

    initial begin
        // Reset values
        cyc(3);
        check("irq_in_reset", 32'(irq), 32'h0);
        rst = 1'b0;
        cyc(1);
        rd(2'd0, d); check("reset_DATA", d, 32'h0);
        rd(2'd1, d); check("reset_MASK", d, 32'h0);
        rd(2'd2, d); check("reset_EDGE", d, 32'h0);
        rd(2'd3, d); check("reset_CTRL", d, 32'h1);

        // Clean rising edge on bit 0: visible exactly L edges after the step
        in_export[0] = 1'b1;
        cyc(L-1);
        rd(2'd0, d); check("rise_DATA_edge_L_pre", d, 32'h0);
        rd(2'd0, d); check("rise_DATA_after_L", d, 32'h1);
        rd(2'd2, d); check("rise_EDGE", d, 32'h1);
        check("rise_irq_unmasked", 32'(irq), 32'h0);
        wr(2'd1, 32'h01);
        check("rise_irq_after_mask", 32'(irq), 32'h1);

        // Glitch of 3 synchronised cycles on bit 2
        in_export[2] = 1'b1;
        cyc(3);
        in_export[2] = 1'b0;
        cyc(L+4);
        rd(2'd0, d); check("glitch_DATA", d, 32'h1);
        rd(2'd2, d); check("glitch_EDGE", d, (DC_EFF > 3) ? 32'h1 : 32'h5);
        check("glitch_irq", 32'(irq), 32'h1);
        wr(2'd2, 32'h04);

        // W1C: plain clear, then a clear racing a new capture, then plain clear again
        in_export[0] = 1'b0;
        cyc(L+2);
        check("w1c_irq_before", 32'(irq), 32'h1);
        wr(2'd2, 32'h01);
        check("w1c_irq_dropped", 32'(irq), 32'h0);
        rd(2'd2, d); check("w1c_EDGE_cleared", d, 32'h0);
        in_export[0] = 1'b1;
        cyc(L-1);
        wr(2'd2, 32'h01);
        rd(2'd2, d); check("w1c_race_set_wins", d, 32'h1);
        check("w1c_race_irq", 32'(irq), 32'h1);
        wr(2'd2, 32'h01);
        check("w1c_repeat_irq", 32'(irq), 32'h0);
        rd(2'd2, d); check("w1c_repeat_EDGE", d, 32'h0);

        // Falling-only mode on bit 3
        wr(2'd3, 32'h2);
        rd(2'd3, d); check("ctrl_readback", d, 32'h2);
        in_export[3] = 1'b1;
        cyc(L+3);
        rd(2'd2, d); check("fall_press_no_edge", d, 32'h0);
        in_export[3] = 1'b0;
        cyc(L-1);
        rd(2'd2, d); check("fall_edge_L_pre", d, 32'h0);
        rd(2'd2, d); check("fall_release_edge", d, 32'h8);

        // Reset in the middle of a debounce on bit 1
        wr(2'd2, 32'hFF);
        in_export = '0;
        cyc(L+2);
        in_export[1] = 1'b1;
        cyc(SS+2);
        rst = 1'b1;
        in_export = '0;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        rd(2'd0, d); check("midrst_DATA", d, 32'h0);
        rd(2'd1, d); check("midrst_MASK", d, 32'h0);
        rd(2'd2, d); check("midrst_EDGE", d, 32'h0);
        rd(2'd3, d); check("midrst_CTRL", d, 32'h1);
        cyc(20);
        rd(2'd2, d); check("midrst_no_edge_20", d, 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);

        // Randomised traffic against the model
        wr(2'd3, 32'h3);
        wr(2'd1, 32'hFF);
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = int'($urandom_range(0, W-1));
                in_export[b] = ~in_export[b];
            end
            op = int'($urandom_range(0, 7));
            avs_address   = 2'($urandom_range(0, 3));
            avs_writedata = $urandom;
            avs_read      = (op <= 2) || (op == 4);
            avs_write     = (op == 3) || (op == 4);
            if (avs_write && avs_address == 2'd3 && $urandom_range(0, 3) != 0)
                avs_writedata[1:0] = 2'b11;
            cyc(1);
            avs_read  = 1'b0;
            avs_write = 1'b0;
        end
        cyc(L+2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
